// File: rtl/multicycle_control.sv
// Multi-cycle LEGv8 sequencer: steps FETCH/DECODE/EXEC/MEM/WB around one shared ALU
// and one memory port, stalls on MemReady, traps illegal opcodes and memory timeouts.
module multicycle_control #(
   parameter int MEM_TIMEOUT = 15,
   parameter int CNT_W       = 32
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic [10:0]      OPCode,
   input  logic             Zero,
   input  logic             MemReady,
   output logic             IRWrite,
   output logic             PCWrite,
   output logic             PCSrc,
   output logic             MemRead,
   output logic             MemWrite,
   output logic             IorD,
   output logic             ALUSrcA,
   output logic [1:0]       ALUSrcB,
   output logic [1:0]       ALUOP,
   output logic             Reg2Loc,
   output logic             RegWrite,
   output logic             MemToReg,
   output logic             InstrDone,
   output logic             Fault,
   output logic [2:0]       State,
   output logic [CNT_W-1:0] RetireCount
);

   localparam logic [2:0] S_FETCH  = 3'd0;
   localparam logic [2:0] S_DECODE = 3'd1;
   localparam logic [2:0] S_EXEC   = 3'd2;
   localparam logic [2:0] S_MEM    = 3'd3;
   localparam logic [2:0] S_WB     = 3'd4;
   localparam logic [2:0] S_FAULT  = 3'd7;

   localparam logic [2:0] C_ILLEGAL = 3'd0;
   localparam logic [2:0] C_RTYPE   = 3'd1;
   localparam logic [2:0] C_LDUR    = 3'd2;
   localparam logic [2:0] C_STUR    = 3'd3;
   localparam logic [2:0] C_CBZ     = 3'd4;
   localparam logic [2:0] C_B       = 3'd5;

   localparam logic [7:0] WAIT_LIMIT = 8'(MEM_TIMEOUT);

   logic [2:0] state;
   logic [2:0] next_state;
   logic [2:0] op_class;
   logic [2:0] dec_class;
   logic [7:0] wait_cnt;
   logic       timed_out;

   always_comb begin
      dec_class = C_ILLEGAL;
      casez (OPCode)
         11'b11111000010: dec_class = C_LDUR;
         11'b11111000000: dec_class = C_STUR;
         11'b10110100???: dec_class = C_CBZ;
         11'b000101?????: dec_class = C_B;
         11'b10001011000,
         11'b11001011000,
         11'b10001010000,
         11'b10101010000,
         11'b11010011011,
         11'b11010011010: dec_class = C_RTYPE;
         default:         dec_class = C_ILLEGAL;
      endcase
   end

   // A ready in the limit cycle still completes the access; only a miss there faults.
   assign timed_out = (wait_cnt == WAIT_LIMIT) && !MemReady;

   always_comb begin
      next_state = state;
      case (state)
         S_FETCH: begin
            if (MemReady)       next_state = S_DECODE;
            else if (timed_out) next_state = S_FAULT;
         end
         S_DECODE: begin
            if (dec_class == C_B)            next_state = S_FETCH;
            else if (dec_class == C_ILLEGAL) next_state = S_FAULT;
            else                             next_state = S_EXEC;
         end
         S_EXEC: begin
            case (op_class)
               C_RTYPE:        next_state = S_WB;
               C_LDUR, C_STUR: next_state = S_MEM;
               C_CBZ:          next_state = S_FETCH;
               default:        next_state = S_FAULT;
            endcase
         end
         S_MEM: begin
            if (MemReady)       next_state = (op_class == C_LDUR) ? S_WB : S_FETCH;
            else if (timed_out) next_state = S_FAULT;
         end
         S_WB:    next_state = S_FETCH;
         default: next_state = S_FAULT;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state       <= S_FETCH;
         op_class    <= C_ILLEGAL;
         wait_cnt    <= 8'd0;
         RetireCount <= '0;
      end else begin
         state <= next_state;
         if (state == S_DECODE)
            op_class <= dec_class;
         // Counter restarts whenever a new state (and so a new access) begins.
         if (next_state != state)
            wait_cnt <= 8'd0;
         else if (state == S_FETCH || state == S_MEM)
            wait_cnt <= wait_cnt + 8'd1;
         if (InstrDone)
            RetireCount <= RetireCount + 1'b1;
      end
   end

   always_comb begin
      IRWrite   = 1'b0;
      PCWrite   = 1'b0;
      PCSrc     = 1'b0;
      MemRead   = 1'b0;
      MemWrite  = 1'b0;
      IorD      = 1'b0;
      ALUSrcA   = 1'b0;
      ALUSrcB   = 2'b00;
      ALUOP     = 2'b00;
      Reg2Loc   = 1'b0;
      RegWrite  = 1'b0;
      MemToReg  = 1'b0;
      InstrDone = 1'b0;
      case (state)
         S_FETCH: begin
            MemRead = 1'b1;
            ALUSrcB = 2'b01;
            IRWrite = MemReady;
            PCWrite = MemReady;
         end
         S_DECODE: begin
            ALUSrcB = 2'b10;
            if (dec_class == C_B) begin
               PCWrite   = 1'b1;
               PCSrc     = 1'b1;
               InstrDone = 1'b1;
            end
         end
         S_EXEC: begin
            case (op_class)
               C_RTYPE: begin
                  ALUSrcA = 1'b1;
                  ALUOP   = 2'b10;
               end
               C_LDUR, C_STUR: begin
                  ALUSrcA = 1'b1;
                  ALUSrcB = 2'b10;
                  Reg2Loc = (op_class == C_STUR);
               end
               C_CBZ: begin
                  Reg2Loc   = 1'b1;
                  ALUOP     = 2'b01;
                  PCWrite   = Zero;
                  PCSrc     = 1'b1;
                  InstrDone = 1'b1;
               end
               default: ;
            endcase
         end
         S_MEM: begin
            IorD      = 1'b1;
            MemRead   = (op_class == C_LDUR);
            MemWrite  = (op_class == C_STUR);
            InstrDone = MemReady && (op_class == C_STUR);
         end
         S_WB: begin
            RegWrite  = 1'b1;
            MemToReg  = (op_class == C_LDUR);
            InstrDone = 1'b1;
         end
         default: ;
      endcase
      // Any request in flight is simply dropped while reset is held.
      if (RESET) begin
         IRWrite   = 1'b0;
         PCWrite   = 1'b0;
         PCSrc     = 1'b0;
         MemRead   = 1'b0;
         MemWrite  = 1'b0;
         IorD      = 1'b0;
         ALUSrcA   = 1'b0;
         ALUSrcB   = 2'b00;
         ALUOP     = 2'b00;
         Reg2Loc   = 1'b0;
         RegWrite  = 1'b0;
         MemToReg  = 1'b0;
         InstrDone = 1'b0;
      end
   end

   assign State = state;
   assign Fault = (state == S_FAULT);

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: walks instructions phase by phase with random MemReady
// waits and compares every cycle's control word against an instruction-level model.
module tb_multicycle_control;

   localparam int MEM_TIMEOUT = 15;
   localparam int CNT_W       = 4;

   // Control word bit positions: {State[2:0], IRWrite .. InstrDone, Fault}
   localparam int P_IRW  = 15;
   localparam int P_PCW  = 14;
   localparam int P_PCS  = 13;
   localparam int P_MR   = 12;
   localparam int P_MW   = 11;
   localparam int P_IORD = 10;
   localparam int P_ASA  = 9;
   localparam int P_ASB  = 7;
   localparam int P_AOP  = 5;
   localparam int P_R2L  = 4;
   localparam int P_RW   = 3;
   localparam int P_M2R  = 2;
   localparam int P_DONE = 1;

   localparam logic [10:0] OP_LDUR = 11'b11111000010;
   localparam logic [10:0] OP_STUR = 11'b11111000000;
   localparam logic [10:0] OP_ADD  = 11'b10001011000;
   localparam logic [10:0] R_OPS [6] = '{11'b10001011000, 11'b11001011000, 11'b10001010000,
                                         11'b10101010000, 11'b11010011011, 11'b11010011010};

   typedef enum int {K_ILL, K_LDUR, K_STUR, K_CBZ, K_B, K_R} kind_t;

   logic CLK = 1'b0;
   logic RESET = 1'b1;
   logic [10:0] OPCode = '0;
   logic Zero = 1'b0;
   logic MemReady = 1'b0;
   logic IRWrite, PCWrite, PCSrc, MemRead, MemWrite, IorD, ALUSrcA;
   logic [1:0] ALUSrcB, ALUOP;
   logic Reg2Loc, RegWrite, MemToReg, InstrDone, Fault;
   logic [2:0] State;
   logic [CNT_W-1:0] RetireCount;
   logic [18:0] actVec;

   int vecCount = 0;
   int missCount = 0;
   int modelCount = 0;
   bit needReset = 1'b0;

   always #5 CLK = ~CLK;

   multicycle_control #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
      .CLK(CLK), .RESET(RESET), .OPCode(OPCode), .Zero(Zero), .MemReady(MemReady),
      .IRWrite(IRWrite), .PCWrite(PCWrite), .PCSrc(PCSrc), .MemRead(MemRead),
      .MemWrite(MemWrite), .IorD(IorD), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
      .ALUOP(ALUOP), .Reg2Loc(Reg2Loc), .RegWrite(RegWrite), .MemToReg(MemToReg),
      .InstrDone(InstrDone), .Fault(Fault), .State(State), .RetireCount(RetireCount)
   );

   assign actVec = {State, IRWrite, PCWrite, PCSrc, MemRead, MemWrite, IorD, ALUSrcA,
                    ALUSrcB, ALUOP, Reg2Loc, RegWrite, MemToReg, InstrDone, Fault};

   function automatic kind_t classOf(input logic [10:0] o);
      if (o == OP_LDUR) return K_LDUR;
      if (o == OP_STUR) return K_STUR;
      if (o[10:3] == 8'b10110100) return K_CBZ;
      if (o[10:5] == 6'b000101) return K_B;
      for (int i = 0; i < 6; i++)
         if (o == R_OPS[i]) return K_R;
      return K_ILL;
   endfunction

   function automatic logic [18:0] stateWord(input int s);
      return {3'(s), 16'b0};
   endfunction

   task automatic checkOutput(input string tag, input logic [18:0] got, input logic [18:0] want);
      vecCount++;
      if (got !== want) begin
         missCount++;
         $display("[TB] FAIL %s: got %h expected %h (t=%0t)", tag, got, want, $time);
      end
   endtask

   task automatic applyStimulus(input string tag, input logic [18:0] want, input logic rdy,
                                input logic zro, input logic [10:0] opc);
      @(negedge CLK);
      RESET = 1'b0;
      MemReady = rdy;
      Zero = zro;
      OPCode = opc;
      #1;
      checkOutput(tag, actVec, want);
   endtask

   task automatic faultCycles(input int n);
      for (int i = 0; i < n; i++)
         applyStimulus("fault", {3'd7, 15'b0, 1'b1}, 1'($urandom), 1'($urandom), 11'($urandom));
      needReset = 1'b1;
   endtask

   task automatic applyReset(input int n, input int expState);
      for (int i = 0; i < n; i++) begin
         @(negedge CLK);
         RESET = 1'b1;
         MemReady = 1'($urandom);
         Zero = 1'($urandom);
         OPCode = 11'($urandom);
         #1;
         if (i == 0) begin
            checkOutput("rst_cmd", 19'(actVec[15:1]), 19'd0);
            if (expState >= 0) checkOutput("rst_state", 19'(State), 19'(expState));
         end else begin
            checkOutput("rst_vec", actVec, 19'd0);
            checkOutput("rst_cnt", 19'(RetireCount), 19'd0);
         end
      end
      modelCount = 0;
      needReset = 1'b0;
   endtask

   // One instruction: fw/mw are wait cycles before MemReady in fetch/memory; abortMem>=0
   // leaves the memory phase at that cycle so the caller can reset mid-access.
   task automatic runInstr(input logic [10:0] opc, input int fw, input int mw,
                           input logic zv, input int abortMem);
      kind_t k;
      logic [18:0] e;
      logic rdy;
      k = classOf(opc);
      for (int i = 0; i <= fw; i++) begin
         rdy = (i == fw);
         e = stateWord(0);
         e[P_MR] = 1'b1;
         e[P_ASB +: 2] = 2'b01;
         e[P_IRW] = rdy;
         e[P_PCW] = rdy;
         applyStimulus("fetch", e, rdy, 1'($urandom), 11'($urandom));
         if (!rdy && i == MEM_TIMEOUT) begin
            faultCycles(3);
            return;
         end
      end
      e = stateWord(1);
      e[P_ASB +: 2] = 2'b10;
      if (k == K_B) begin
         e[P_PCW] = 1'b1;
         e[P_PCS] = 1'b1;
         e[P_DONE] = 1'b1;
      end
      applyStimulus("decode", e, 1'($urandom), 1'($urandom), opc);
      if (k == K_ILL) begin
         faultCycles(3);
         return;
      end
      if (k != K_B) begin
         e = stateWord(2);
         case (k)
            K_R: begin
               e[P_ASA] = 1'b1;
               e[P_AOP +: 2] = 2'b10;
            end
            K_LDUR, K_STUR: begin
               e[P_ASA] = 1'b1;
               e[P_ASB +: 2] = 2'b10;
               e[P_R2L] = (k == K_STUR);
            end
            default: begin
               e[P_R2L] = 1'b1;
               e[P_AOP +: 2] = 2'b01;
               e[P_PCW] = zv;
               e[P_PCS] = 1'b1;
               e[P_DONE] = 1'b1;
            end
         endcase
         applyStimulus("exec", e, 1'($urandom), (k == K_CBZ) ? zv : 1'($urandom), opc);
         if (k == K_LDUR || k == K_STUR) begin
            for (int i = 0; i <= mw; i++) begin
               if (i == abortMem) begin
                  needReset = 1'b1;
                  return;
               end
               rdy = (i == mw);
               e = stateWord(3);
               e[P_IORD] = 1'b1;
               e[P_MR] = (k == K_LDUR);
               e[P_MW] = (k == K_STUR);
               e[P_DONE] = rdy && (k == K_STUR);
               applyStimulus("mem", e, rdy, 1'($urandom), opc);
               if (!rdy && i == MEM_TIMEOUT) begin
                  faultCycles(3);
                  return;
               end
            end
         end
         if (k == K_R || k == K_LDUR) begin
            e = stateWord(4);
            e[P_RW] = 1'b1;
            e[P_M2R] = (k == K_LDUR);
            e[P_DONE] = 1'b1;
            applyStimulus("wb", e, 1'($urandom), 1'($urandom), opc);
         end
      end
      modelCount = (modelCount + 1) % (2 ** CNT_W);
      @(posedge CLK);
      #1;
      checkOutput("retire", 19'(RetireCount), 19'(modelCount));
   endtask

   function automatic logic [10:0] randomOpcode();
      int r;
      r = $urandom_range(0, 19);
      if (r == 0)  return 11'($urandom);
      if (r <= 3)  return OP_LDUR;
      if (r <= 6)  return OP_STUR;
      if (r <= 9)  return {8'b10110100, 3'($urandom)};
      if (r <= 12) return {6'b000101, 5'($urandom)};
      return R_OPS[$urandom_range(0, 5)];
   endfunction

   function automatic int randomWait();
      if ($urandom_range(0, 9) == 0) return $urandom_range(0, MEM_TIMEOUT + 2);
      return $urandom_range(0, 2);
   endfunction

   initial begin
      applyReset(3, -1);
      runInstr(OP_ADD, 0, 0, 1'b0, -1);
      runInstr(OP_LDUR, 0, 3, 1'b0, -1);
      runInstr(11'b10110100101, 0, 0, 1'b1, -1);
      runInstr(11'b10110100010, 0, 0, 1'b0, -1);
      runInstr(11'b00010110011, 0, 0, 1'b0, -1);
      runInstr(11'b11111111111, 0, 0, 1'b0, -1);
      if (needReset) applyReset(2, -1);
      runInstr(OP_ADD, MEM_TIMEOUT + 1, 0, 1'b0, -1);
      if (needReset) applyReset(2, -1);
      runInstr(OP_ADD, MEM_TIMEOUT, 0, 1'b0, -1);
      runInstr(OP_STUR, 1, MEM_TIMEOUT + 5, 1'b0, -1);
      if (needReset) applyReset(2, -1);
      runInstr(OP_STUR, 0, 5, 1'b0, 2);
      if (needReset) applyReset(2, 3);
      for (int i = 0; i < 16; i++)
         runInstr({6'b000101, 5'(i)}, 0, 0, 1'b0, -1);
      for (int i = 0; i < 120; i++) begin
         runInstr(randomOpcode(), randomWait(), randomWait(), 1'($urandom), -1);
         if (needReset) applyReset(2, -1);
      end
      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

endmodule
